ebus_pi_responder: RTL and testbench

- Device-side EBUS interrupt agent directly upstream of the PI controller.
- Raises a device interrupt on the EBUS PI request line for its assigned level (PIA).
- Answers the controller's PI-serve cycle by asserting its physical-number bit.
- When selected, supplies the interrupt function word with a xfer handshake. One instance per internal or external EBUS device.

---
 rtl/ebus_pi_if.sv | 12 +
 rtl/ebus_pi_responder.sv | 128 ++++++++++++
 tb/tb_ebus_pi_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ebus_pi_if.sv
// ebus_pi_if: EBUS PI bus between the PI controller (master) and a device responder (slave)
interface ebus_pi_if;
  logic        ebus_demand;
  logic [2:0]  ebus_func;
  logic [0:3]  ebus_cs;
  logic [1:7]  ebus_pi;
  logic [0:35] ebus_data;
  logic        ebus_drive;
  logic        ebus_xfer;
  modport master(output ebus_demand, ebus_func, ebus_cs, input ebus_pi, ebus_data, ebus_drive, ebus_xfer);
  modport slave(input ebus_demand, ebus_func, ebus_cs, output ebus_pi, ebus_data, ebus_drive, ebus_xfer);
endinterface

// File: rtl/ebus_pi_responder.sv
// ebus_pi_responder: device-side EBUS PI agent (request, serve, vector); EBUS_PI_TIMEOUT_EN adds a stuck-demand timeout with tmo_err
module ebus_pi_responder #(
`ifdef EBUS_PI_TIMEOUT_EN
  parameter int unsigned TMO_CYC = 64,
`endif
  parameter int unsigned PHY_NO = 4,
  parameter logic [2:0] FUNC_SERVE = 3'b100,
  parameter logic [2:0] FUNC_VECTOR = 3'b101,
  parameter logic [0:35] VEC_WORD = 36'o000000_000040
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       dev_int,
  input  logic       cono_load,
  input  logic [2:0] pia_in,
  ebus_pi_if.slave   bus,
  output logic [2:0] pia,
  output logic       busy
`ifdef EBUS_PI_TIMEOUT_EN
  ,
  output logic       tmo_err
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, SERVE, WAITSEL, VECTOR, ACKED} state_t;
  localparam logic [0:35] SERVE_WORD = 36'd1 << (35 - PHY_NO);
  state_t state;
  logic dev_q;
  logic serve_hit, vec_hit, pia_drop, go;
  assign serve_hit = bus.ebus_demand && bus.ebus_func == FUNC_SERVE && bus.ebus_cs[1:3] == pia;
  assign vec_hit = bus.ebus_demand && bus.ebus_func == FUNC_VECTOR && bus.ebus_cs == 4'(PHY_NO);
  assign pia_drop = cono_load && (pia_in == 3'd0 || pia_in != pia);
  assign go = dev_q && pia != 3'd0 && !pia_drop;
  assign bus.ebus_pi = (state inside {REQ, SERVE, WAITSEL} && pia != 3'd0) ? 7'b1000000 >> (pia - 3'd1) : 7'd0;
`ifdef EBUS_PI_TIMEOUT_EN
  state_t last;
  logic [6:0] cnt, cnt_nx;
  logic tmo_hit;
  assign cnt_nx = !(state inside {SERVE, WAITSEL, VECTOR}) ? 7'd0 : state != last ? 7'd1 : cnt + 7'd1;
  assign tmo_hit = cnt_nx == 7'(TMO_CYC) && !pia_drop;
`endif
  // Interrupt handshake FSM; data/drive/xfer/busy are registered alongside the state transition
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      pia <= 3'd0;
      dev_q <= 1'b0;
      busy <= 1'b0;
      bus.ebus_data <= '0;
      bus.ebus_drive <= 1'b0;
      bus.ebus_xfer <= 1'b0;
`ifdef EBUS_PI_TIMEOUT_EN
      last <= IDLE;
      cnt <= 7'd0;
      tmo_err <= 1'b0;
`endif
    end else begin
      dev_q <= dev_int;
      if (cono_load) pia <= pia_in;
      bus.ebus_data <= '0;
      bus.ebus_drive <= 1'b0;
      bus.ebus_xfer <= 1'b0;
      case (state)
        IDLE: begin
          state <= go ? REQ : IDLE;
          busy <= go;
        end
        REQ: begin
          if (pia_drop || !dev_q) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (serve_hit) begin
            state <= SERVE;
            bus.ebus_drive <= 1'b1;
            bus.ebus_data <= SERVE_WORD;
          end
        end
        SERVE: begin
          if (pia_drop) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (bus.ebus_demand) begin
            bus.ebus_drive <= 1'b1;
            bus.ebus_data <= SERVE_WORD;
          end else state <= WAITSEL;
        end
        WAITSEL: begin
          if (vec_hit) begin
            state <= VECTOR;
            bus.ebus_drive <= 1'b1;
            bus.ebus_xfer <= 1'b1;
            bus.ebus_data <= VEC_WORD;
          end else if (serve_hit) begin
            state <= SERVE;
            bus.ebus_drive <= 1'b1;
            bus.ebus_data <= SERVE_WORD;
          end else if (!dev_q) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        VECTOR: begin
          if (bus.ebus_demand) begin
            bus.ebus_drive <= 1'b1;
            bus.ebus_xfer <= 1'b1;
            bus.ebus_data <= VEC_WORD;
          end else state <= ACKED;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
`ifdef EBUS_PI_TIMEOUT_EN
      last <= state;
      cnt <= cnt_nx;
      if (cono_load) tmo_err <= 1'b0;
      if (tmo_hit) begin
        state <= REQ;
        busy <= 1'b1;
        bus.ebus_data <= '0;
        bus.ebus_drive <= 1'b0;
        bus.ebus_xfer <= 1'b0;
        tmo_err <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ebus_pi_responder.sv
// tb_ebus_pi_responder: table-driven vectors plus hand sequences for the EBUS PI responder
module tb_ebus_pi_responder;
  logic clk = 1'b0;
  logic RESET, dev_int, cono_load, busy;
  logic [2:0] pia_in, pia;
`ifdef EBUS_PI_TIMEOUT_EN
  logic tmo_err;
`endif
  int applied = 0, misc = 0, ncmp = 0;
  always #5 clk = ~clk;
  ebus_pi_if bus();
  ebus_pi_responder dut (
    .clk(clk), .RESET(RESET), .dev_int(dev_int), .cono_load(cono_load), .pia_in(pia_in),
    .bus(bus), .pia(pia), .busy(busy)
`ifdef EBUS_PI_TIMEOUT_EN
    , .tmo_err(tmo_err)
`endif
  );
  localparam logic [0:35] SW = 36'o020000_000000;
  localparam logic [0:35] VW = 36'o000000_000040;
  localparam logic [1:7] P3 = 7'b0010000;
  localparam logic [1:7] P5 = 7'b0000100;
  localparam logic [2:0] S = 3'b100;
  localparam logic [2:0] V = 3'b101;
  typedef struct {
    string name;
    logic rst, dev, cono;
    logic [2:0] pin;
    logic dem;
    logic [2:0] fn;
    logic [0:3] cs;
    logic [1:7] pi;
    logic [0:35] data;
    logic drv, xf, bsy;
    logic [2:0] pia;
  } vec_t;
  vec_t tv[$];
  task automatic add(string n, logic r, logic d, logic c, logic [2:0] pin, logic dem, logic [2:0] fn,
                     logic [0:3] cs, logic [1:7] pi, logic [0:35] data, logic drv, logic xf, logic bsy, logic [2:0] p);
    vec_t v;
    v = '{n, r, d, c, pin, dem, fn, cs, pi, data, drv, xf, bsy, p};
    tv.push_back(v);
  endtask
  task automatic chk(string n, string f, logic [35:0] act, logic [35:0] exp);
    ncmp++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s.%s: got %h want %h", n, f, act, exp);
    end
  endtask
  task automatic drive(logic r, logic d, logic c, logic [2:0] pin, logic dem, logic [2:0] fn, logic [0:3] cs);
    RESET = r;
    dev_int = d;
    cono_load = c;
    pia_in = pin;
    bus.ebus_demand = dem;
    bus.ebus_func = fn;
    bus.ebus_cs = cs;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    drive(1, 0, 0, 0, 0, 0, 0);
    add("rst",            1,0,0,0, 0,0,4'd0,    0, 0, 0,0,0, 0);
    add("cono3",          0,0,1,3, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("dev_sync",       0,1,0,0, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("req",            0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("serve",          0,1,0,0, 1,S,4'b0011, P3,SW,1,0,1, 3);
    add("serve_hold",     0,1,0,0, 1,S,4'b0011, P3,SW,1,0,1, 3);
    add("waitsel",        0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("vector",         0,1,0,0, 1,V,4'd4,    0, VW,1,1,1, 3);
    add("vector_hold",    0,1,0,0, 1,V,4'd4,    0, VW,1,1,1, 3);
    add("acked",          0,1,0,0, 0,0,4'd0,    0, 0, 0,0,1, 3);
    add("idle_after_ack", 0,1,0,0, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("rereq",          0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("wrong_lvl",      0,1,0,0, 1,S,4'b0101, P3,0, 0,0,1, 3);
    add("req_stay",       0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("serve2",         0,1,0,0, 1,S,4'b0011, P3,SW,1,0,1, 3);
    add("waitsel2",       0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("vec_other",      0,1,0,0, 1,V,4'd7,    P3,0, 0,0,1, 3);
    add("waitsel3",       0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("reserve",        0,1,0,0, 1,S,4'b0011, P3,SW,1,0,1, 3);
    add("waitsel4",       0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("vector2",        0,1,0,0, 1,V,4'd4,    0, VW,1,1,1, 3);
    add("acked2",         0,1,0,0, 0,0,4'd0,    0, 0, 0,0,1, 3);
    add("idle2",          0,0,0,0, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("dev_sync2",      0,1,0,0, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("req3",           0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("cono_off",       0,1,1,0, 0,0,4'd0,    0, 0, 0,0,0, 0);
    add("off_idle",       0,1,0,0, 0,0,4'd0,    0, 0, 0,0,0, 0);
    add("cono3_again",    0,1,1,3, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("req4",           0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("cono_vs_serve",  0,1,1,5, 1,S,4'b0011, 0, 0, 0,0,0, 5);
    add("req5",           0,1,0,0, 0,0,4'd0,    P5,0, 0,0,1, 5);
    add("serve5",         0,1,0,0, 1,S,4'b0101, P5,SW,1,0,1, 5);
    add("dev_fall_serve", 0,0,0,0, 0,0,4'd0,    P5,0, 0,0,1, 5);
    add("waitsel_drop",   0,0,0,0, 0,0,4'd0,    0, 0, 0,0,0, 5);
    add("cono3b",         0,1,1,3, 0,0,4'd0,    0, 0, 0,0,0, 3);
    add("req6",           0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("serve6",         0,1,0,0, 1,S,4'b0011, P3,SW,1,0,1, 3);
    add("waitsel6",       0,1,0,0, 0,0,4'd0,    P3,0, 0,0,1, 3);
    add("vector6",        0,1,0,0, 1,V,4'd4,    0, VW,1,1,1, 3);
    add("rst_mid_vec",    1,1,0,0, 1,V,4'd4,    0, 0, 0,0,0, 0);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].dev, tv[i].cono, tv[i].pin, tv[i].dem, tv[i].fn, tv[i].cs);
      step();
      applied++;
      chk(tv[i].name, "pi", 36'(bus.ebus_pi), 36'(tv[i].pi));
      chk(tv[i].name, "data", bus.ebus_data, tv[i].data);
      chk(tv[i].name, "drive", 36'(bus.ebus_drive), 36'(tv[i].drv));
      chk(tv[i].name, "xfer", 36'(bus.ebus_xfer), 36'(tv[i].xf));
      chk(tv[i].name, "busy", 36'(busy), 36'(tv[i].bsy));
      chk(tv[i].name, "pia", 36'(pia), 36'(tv[i].pia));
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 6, 0, 0, 0);
    step();
    drive(0, 1, 0, 0, 0, 0, 0);
    n = 0;
    while (bus.ebus_pi == 7'd0 && n < 10) begin
      step();
      n++;
    end
    applied++;
    chk("lat6", "cycles", 36'(n), 36'd2);
    chk("lat6", "pi", 36'(bus.ebus_pi), 36'b0000010);
    drive(0, 1, 0, 0, 1, S, 4'b0110);
    step();
    applied++;
    chk("serve6_lat", "drive", 36'(bus.ebus_drive), 36'd1);
    chk("serve6_lat", "data", bus.ebus_data, SW);
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 0, 1, V, 4'd4);
    step();
    applied++;
    chk("vec6_lat", "xfer", 36'(bus.ebus_xfer), 36'd1);
    chk("vec6_lat", "data", bus.ebus_data, VW);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    applied++;
    chk("ack6", "pi", 36'(bus.ebus_pi), 36'd0);
    chk("ack6", "busy", 36'(busy), 36'd1);
    chk("ack6", "xfer", 36'(bus.ebus_xfer), 36'd0);
    step();
    applied++;
    chk("idle6", "busy", 36'(busy), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, misc);
    $finish;
  end
endmodule
